// File: rtl/dw_conv_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_REQ valid/ready beat streams
// into the single input stream of a width converter, tagging each beat with its source.
module dw_conv_rr_arbiter #(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_DW = 512,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ*DATA_DW-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [DATA_DW-1:0]         conv_data_o,
  output logic                       conv_valid_o,
  input  logic                       conv_ready_i,
  output logic                       conv_last_o,
  output logic [ID_W-1:0]            conv_id_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o
);

  // Handshake: a beat moves on a rising clk_i edge when valid and ready are both
  // high on that edge; ready may depend combinationally on the downstream ready.

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      ptr_q;
  logic [NUM_REQ-1:0]   grant_q;

  logic [DATA_DW-1:0]   beats [NUM_REQ];
  logic [2*NUM_REQ-1:0] rot_valid;
  logic [ID_W:0]        cand;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic [ID_W-1:0]      next_ptr;
  logic                 hs;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign beats[i] = req_data_i[i*DATA_DW +: DATA_DW];
  end

  // Bit k of rot_valid is the valid of requester (ptr_q + k) mod NUM_REQ.
  assign rot_valid = {req_valid_i, req_valid_i} >> ptr_q;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        cand  = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) begin
          cand = cand - (ID_W+1)'(NUM_REQ);
        end
        win = cand[ID_W-1:0];
      end
    end
  end

  assign next_ptr = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
  assign hs       = conv_valid_o && conv_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= LOCKED;
            id_q    <= win;
            grant_q <= NUM_REQ'(1) << win;
          end
        end
        LOCKED: begin
          // Only the last beat's handshake releases; valid gaps keep the lock.
          if (hs && req_last_i[id_q]) begin
            state_q <= IDLE;
            ptr_q   <= next_ptr;
            id_q    <= '0;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          id_q    <= '0;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    conv_data_o  = '0;
    conv_valid_o = 1'b0;
    conv_last_o  = 1'b0;
    req_ready_o  = '0;
    if (state_q == LOCKED) begin
      conv_data_o       = beats[id_q];
      conv_valid_o      = req_valid_i[id_q];
      conv_last_o       = req_last_i[id_q];
      req_ready_o[id_q] = conv_ready_i;
    end
  end

  assign conv_id_o = id_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q == LOCKED);

endmodule

// File: tb/tb_dw_conv_rr_arbiter.sv
// Directed and randomized bench for dw_conv_rr_arbiter against a per-cycle
// packet-level reference model and per-requester expected beat queues.
module tb_dw_conv_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]   conv_data;
  logic            conv_valid, conv_ready, conv_last;
  logic [IW-1:0]   conv_id;
  logic [N-1:0]    grant;
  logic            busy;

  int errors = 0;
  int checks = 0;

  logic [DW:0] src_q[N][$];
  logic [DW:0] exp_q[N][$];
  logic [N-1:0] en;
  bit   rnd_ready;
  int   hs_ids[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   seq = 0;

  bit m_locked;
  int m_owner, m_prio;

  always #5 clk = ~clk;

  dw_conv_rr_arbiter #(.NUM_REQ(N), .DATA_DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .conv_data_o(conv_data), .conv_valid_o(conv_valid), .conv_ready_i(conv_ready),
    .conv_last_o(conv_last), .conv_id_o(conv_id), .grant_o(grant), .busy_o(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hs_at(input int i);
    return (i < hs_ids.size()) ? hs_ids[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1000;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        logic [DW:0] h;
        h = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = h[DW-1:0];
        req_last[i] = h[DW];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = {$urandom, $urandom};
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
    if (rnd_ready) conv_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_pkt(input int id, input int len);
    for (int b = 0; b < len; b++) begin
      logic [DW:0] beat;
      beat = {(b == len - 1), 8'(id), 24'(seq), 32'($urandom)};
      seq++;
      src_q[id].push_back(beat);
      exp_q[id].push_back(beat);
    end
    apply_inputs();
  endtask

  // Expected outputs follow directly from the model's lock status and owner.
  task automatic check_outputs();
    logic [DW-1:0] e_data;
    logic          e_valid, e_last, e_busy;
    logic [N-1:0]  e_ready, e_grant, one;
    int            e_id;
    one = 1;
    e_data = '0; e_valid = 0; e_last = 0; e_busy = 0; e_ready = '0; e_grant = '0; e_id = 0;
    if (m_locked) begin
      e_data  = req_data[m_owner*DW +: DW];
      e_valid = req_valid[m_owner];
      e_last  = req_last[m_owner];
      e_ready = conv_ready ? (one << m_owner) : '0;
      e_grant = one << m_owner;
      e_id    = m_owner;
      e_busy  = 1;
    end
    chk("conv_valid", conv_valid, e_valid);
    chk("conv_data", conv_data, e_data);
    chk("conv_last", conv_last, e_last);
    chk("conv_id", conv_id, e_id);
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("req_ready", req_ready, e_ready);
  endtask

  task automatic model_advance();
    bit found;
    found = 0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_prio + k) % N;
        if (!found && req_valid[j]) begin
          found = 1;
          m_owner = j;
        end
      end
      if (found) m_locked = 1;
    end else if (req_valid[m_owner] && conv_ready && req_last[m_owner]) begin
      m_locked = 0;
      m_prio = (m_owner + 1) % N;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (conv_valid && conv_ready) begin
      int id;
      id = int'(conv_id);
      hs_ids.push_back(id);
      hs_cyc.push_back(cyc);
      if (exp_q[id].size() == 0) begin
        chk("sb_extra_beat", exp_q[id].size(), 1);
      end else begin
        logic [DW:0] e;
        e = exp_q[id].pop_front();
        chk("sb_data", conv_data, e[DW-1:0]);
        chk("sb_last", conv_last, e[DW]);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    end
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (hs_ids.size() < n && b < budget) begin
      cycle();
      b++;
    end
    chk(tag, hs_ids.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_conv_valid", conv_valid, 0);
    chk("rst_conv_data", conv_data, 0);
    chk("rst_conv_last", conv_last, 0);
    chk("rst_conv_id", conv_id, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    m_locked = 0; m_prio = 0; m_owner = 0;
    en = '1; rnd_ready = 0; conv_ready = 1'b1;
    hs_ids.delete(); hs_cyc.delete();
    apply_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  initial begin
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_id;
    int pending;
    rst_n = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    conv_ready = 1'b1; rnd_ready = 0; en = '1;
    #2;
    do_reset();

    // Idle stream: nothing forwarded for 10 cycles.
    for (int c = 0; c < 10; c++) cycle();

    // Three-beat packet from requester 2, then pointer sits at 3.
    push_pkt(2, 3);
    run_until(3, 12, "t2_beats");
    for (int i = 0; i < 3; i++) chk("t2_id", hs_at(i), 2);
    chk("t2_back_to_back", cyc_at(2) - cyc_at(0), 2);
    hs_ids.delete(); hs_cyc.delete();
    push_pkt(2, 1);
    push_pkt(3, 1);
    run_until(2, 10, "t2_ptr_beats");
    chk("t2_ptr_first", hs_at(0), 3);
    chk("t2_ptr_second", hs_at(1), 2);

    // All requesters with single-beat packets: rotation 0,1,2,3,0 at 1 beat / 2 cycles.
    do_reset();
    for (int i = 0; i < N; i++) push_pkt(i, 1);
    push_pkt(0, 1);
    run_until(5, 20, "t3_beats");
    chk("t3_id0", hs_at(0), 0);
    chk("t3_id1", hs_at(1), 1);
    chk("t3_id2", hs_at(2), 2);
    chk("t3_id3", hs_at(3), 3);
    chk("t3_id4", hs_at(4), 0);
    for (int i = 0; i < 4; i++) chk("t3_gap", cyc_at(i + 1) - cyc_at(i), 2);

    // Winner drops valid mid-packet: lock holds while requester 0 waits.
    do_reset();
    en = 4'b0010;
    push_pkt(1, 3);
    push_pkt(0, 1);
    run_until(1, 6, "t4_first_beat");
    en = 4'b0001;
    apply_inputs();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t4_grant_held", grant, 4'b0010);
      chk("t4_ready0_low", req_ready[0], 0);
    end
    en = '1;
    apply_inputs();
    run_until(4, 20, "t4_rest");
    chk("t4_id1", hs_at(1), 1);
    chk("t4_id2", hs_at(2), 1);
    chk("t4_id3", hs_at(3), 0);

    // Downstream stall mid-packet: data and id hold, no upstream ready.
    do_reset();
    push_pkt(0, 4);
    push_pkt(2, 2);
    run_until(1, 6, "t5_first_beat");
    conv_ready = 1'b0;
    #1;
    held_data = conv_data;
    held_id = conv_id;
    chk("t5_stall_valid", conv_valid, 1);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("t5_data_stable", conv_data, held_data);
      chk("t5_id_stable", conv_id, held_id);
      chk("t5_ready_low", req_ready[0], 0);
    end
    conv_ready = 1'b1;
    apply_inputs();
    run_until(6, 20, "t5_rest");
    chk("t5_id3", hs_at(3), 0);
    chk("t5_id4", hs_at(4), 2);
    chk("t5_id5", hs_at(5), 2);

    // Reset while locked on requester 3, then pointer restarts at 0.
    do_reset();
    push_pkt(3, 3);
    run_until(1, 6, "t6_lock");
    chk("t6_busy_before", busy, 1);
    chk("t6_grant_before", grant, 4'b1000);
    do_reset();
    push_pkt(3, 1);
    push_pkt(0, 1);
    run_until(2, 10, "t6_beats");
    chk("t6_first", hs_at(0), 0);
    chk("t6_second", hs_at(1), 3);

    // Random traffic, valid gaps and backpressure.
    do_reset();
    rnd_ready = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int id;
        id = $urandom_range(0, N - 1);
        if (src_q[id].size() < 8) push_pkt(id, $urandom_range(1, 4));
      end
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
      apply_inputs();
      cycle();
    end
    rnd_ready = 0;
    conv_ready = 1'b1;
    en = '1;
    apply_inputs();
    for (int c = 0; c < 400; c++) begin
      pending = 0;
      for (int i = 0; i < N; i++) pending += exp_q[i].size();
      if (pending != 0) cycle();
    end
    for (int i = 0; i < N; i++) chk("drain_left", exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
